alu_writeback: RTL

//  Downstream stage of the 8-bit ALU. Accepts each ALU result (out, flag_out) with a destination register,

---
 rtl/alu_writeback_if.sv | 31 +++
 rtl/alu_writeback.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/alu_writeback_if.sv
// ----------------------------------------------------------------------------
// alu_writeback_if
// Result handshake between the ALU (master) and the writeback stage (slave).
//   wb_valid    master->slave  result offered this cycle
//   wb_ready    slave->master  stage can accept (registered)
//   wb_data     master->slave  ALU result
//   wb_flags    master->slave  ALU flags {carry, sign, zero, shift-out}
//   wb_dest     master->slave  destination register
//   wb_flag_we  master->slave  entry also updates the flag register
// ----------------------------------------------------------------------------
interface alu_writeback_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              wb_valid;
    logic              wb_ready;
    logic [DATA_W-1:0] wb_data;
    logic [3:0]        wb_flags;
    logic [ADDR_W-1:0] wb_dest;
    logic              wb_flag_we;

    modport master (
        output wb_valid, wb_data, wb_flags, wb_dest, wb_flag_we,
        input  wb_ready
    );

    modport slave (
        input  wb_valid, wb_data, wb_flags, wb_dest, wb_flag_we,
        output wb_ready
    );
endinterface

// File: rtl/alu_writeback.sv
// ----------------------------------------------------------------------------
// alu_writeback
// Downstream stage of the 8-bit ALU. ALU results are queued in a small FIFO
// and committed, one per cycle and in order, to a register bank plus a 4-bit
// flag register. Two combinational read ports feed the ALU operands.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   wb              result handshake (alu_writeback_if.slave)
//   wr_stall        hold the commit this cycle (bank port borrowed)
//   rd_addr_a/b     read port addresses
//   rd_data_a/b     read port data (combinational)
//   flags           committed flag register
//   pending_mask    bit i set while a queued entry targets register i
//   fifo_count      number of queued entries
//
// Build option
//   ALU_WB_BYPASS_EN  when defined, each read port returns the youngest queued
//                     entry for its address, falling back to the bank.
// ----------------------------------------------------------------------------
module alu_writeback #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    alu_writeback_if.slave            wb,
    input  logic                      wr_stall,
    input  logic [ADDR_W-1:0]         rd_addr_a,
    output logic [DATA_W-1:0]         rd_data_a,
    input  logic [ADDR_W-1:0]         rd_addr_b,
    output logic [DATA_W-1:0]         rd_data_b,
    output logic [3:0]                flags,
    output logic [(1<<ADDR_W)-1:0]    pending_mask,
    output logic [$clog2(DEPTH):0]    fifo_count
);
    localparam int NREG  = 1 << ADDR_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Queue storage carries no reset: only count/pointers define validity.
    logic [DATA_W-1:0] q_data    [DEPTH];
    logic [3:0]        q_flags   [DEPTH];
    logic [ADDR_W-1:0] q_dest    [DEPTH];
    logic              q_flag_we [DEPTH];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              ready;

    logic [DATA_W-1:0] bank [NREG];
    logic [3:0]        flag_reg;

    logic              push;
    logic              pop;

    // Queue slots listed from oldest (k=0) to youngest, with validity.
    logic [PTR_W-1:0]  age_slot [DEPTH];
    logic              age_vld  [DEPTH];

    assign push = wb.wb_valid & ready;
    assign pop  = (count != '0) & ~wr_stall;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    // Ready is registered from the next-state count, so a pop never frees a
    // slot for a push in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            ready <= 1'b0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count <= count_next;
            ready <= (count_next != CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_data[tail]    <= wb.wb_data;
            q_flags[tail]   <= wb.wb_flags;
            q_dest[tail]    <= wb.wb_dest;
            q_flag_we[tail] <= wb.wb_flag_we;
        end
    end

    // Commit stage: head entry lands in the bank (and flags if requested).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                bank[i] <= '0;
            end
            flag_reg <= 4'h0;
        end else if (pop) begin
            bank[q_dest[head]] <= q_data[head];
            if (q_flag_we[head]) begin
                flag_reg <= q_flags[head];
            end
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_age
        assign age_slot[k] = head + PTR_W'(k);
        assign age_vld[k]  = (CNT_W'(k) < count);
    end

    always_comb begin
        pending_mask = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (age_vld[k]) begin
                pending_mask[q_dest[age_slot[k]]] = 1'b1;
            end
        end
    end

`ifdef ALU_WB_BYPASS_EN
    // Later (younger) matches override earlier ones.
    always_comb begin
        rd_data_a = bank[rd_addr_a];
        rd_data_b = bank[rd_addr_b];
        for (int k = 0; k < DEPTH; k++) begin
            if (age_vld[k] && (q_dest[age_slot[k]] == rd_addr_a)) begin
                rd_data_a = q_data[age_slot[k]];
            end
            if (age_vld[k] && (q_dest[age_slot[k]] == rd_addr_b)) begin
                rd_data_b = q_data[age_slot[k]];
            end
        end
    end
`else
    assign rd_data_a = bank[rd_addr_a];
    assign rd_data_b = bank[rd_addr_b];
`endif

    assign wb.wb_ready = ready;
    assign flags       = flag_reg;
    assign fifo_count  = count;
endmodule
